// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Holds the operation and FSM state encodings, the default operand width,
// and small helpers that classify an operation.
package multdiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH + 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Divide class: op[1] set for DIV/DIVU.
    function automatic logic md_is_div(input md_op_t op);
        return op[1];
    endfunction

    // Signed class: op[0] clear for MULT/DIV.
    function automatic logic md_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/multdiv_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div_i  - 1: restoring-divide step, 0: shift-add multiply step
//   acc_i     - product accumulator, or remainder in the low WIDTH+1 bits
//   opa_i     - shifted multiplicand, or dividend/quotient shift register
//   opb_i     - remaining multiplier, or divisor
//   acc_o     - next accumulator / remainder
//   q_bit_o   - quotient bit produced by a divide step (0 for multiply)
module multdiv_iter_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 q_bit_o
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // Remainder never exceeds the divisor, so its top bit is always clear
    // before the shift; the next dividend bit enters from the MSB side.
    assign rem_sh = {acc_i[WIDTH-1:0], opa_i[WIDTH-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, opb_i};

    always_comb begin
        acc_o   = acc_i;
        q_bit_o = 1'b0;
        if (is_div_i) begin
            if (!diff[WIDTH+1]) begin
                acc_o   = W2'(diff[WIDTH:0]);
                q_bit_o = 1'b1;
            end else begin
                acc_o   = W2'(rem_sh);
            end
        end else if (opb_i[0]) begin
            acc_o = acc_i + opa_i;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative multiply/divide controller owning the HI/LO registers.
// A one-cycle start in IDLE latches operand magnitudes, WIDTH iterations run
// in CALC, FIX applies sign correction and writes HI/LO with a done pulse.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start, op    - request strobe (IDLE only) and operation (md_op_t)
//   a, b         - rs / rt operands
//   busy         - operation in flight
//   done, wehilo - one-cycle completion / HI-LO write strobe (identical)
//   hi, lo       - HI (upper product / remainder), LO (lower / quotient)
//   div_by_zero  - last divide had a zero divisor
// Optional: MULTDIV_EARLY_OUT_EN ends multiplies once the multiplier is spent.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wehilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    md_state_t          state_q, state_d;
    md_op_t             op_q, op_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [W2-1:0]      opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [W2-1:0]      step_acc;
    logic               step_q_bit;
    logic               early_out;
    logic [W2-1:0]      prod_fix;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    // Operand magnitudes; |-2^(WIDTH-1)| wraps to itself and is read unsigned.
    assign a_neg = md_is_signed(op) & a[WIDTH-1];
    assign b_neg = md_is_signed(op) & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (md_is_div(op_q)),
        .acc_i    (acc_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc),
        .q_bit_o  (step_q_bit)
    );

`ifdef MULTDIV_EARLY_OUT_EN
    // Multiply may stop once the multiplier after this shift is zero.
    assign early_out = ~md_is_div(op_q) && (opb_q[WIDTH-1:1] == '0);
`else
    assign early_out = 1'b0;
`endif

    // Sign correction; unsigned ops latch both sign flags as zero. The
    // remainder follows the dividend sign, which also restores raw a when
    // the divisor is zero (remainder then equals |a|).
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign rem_fix  = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -opa_q[WIDTH-1:0] : opa_q[WIDTH-1:0];

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    op_d    = op;
                    acc_d   = '0;
                    opa_d   = W2'(a_mag);
                    opb_d   = b_mag;
                    neg_a_d = a_neg;
                    neg_b_d = b_neg;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                opa_d = {opa_q[W2-2:0], md_is_div(op_q) & step_q_bit};
                opb_d = md_is_div(op_q) ? opb_q : (opb_q >> 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1) || early_out) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (md_is_div(op_q)) begin
                    hi_d  = rem_fix;
                    dbz_d = (opb_q == '0);
                    lo_d  = (opb_q == '0) ? '1 : quo_fix;
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wehilo      = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
